// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: inverse S-box, GF(2^8) arithmetic, state encoding.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte r+4c sits at bits [127-8*(r+4c) -: 8] of the 128-bit state.
    function automatic int bidx(input int r, input int c);
        return r + 4 * c;
    endfunction

    function automatic logic [7:0] byte_at(input logic [127:0] s, input int i);
        return s[8*(15-i) +: 8];
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext-in / plaintext-out handshake plus the round-key lookup channel.
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport slave (
        input  in_valid, in_data, rk, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, rk, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round; InvMixColumns is bypassed when last is set.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] nxt
);
    logic [127:0] sr;
    logic [127:0] t;
    logic [127:0] mc;

    always_comb begin
        sr = '0;
        t  = '0;
        mc = '0;
        // Row r rotates right by r: destination column c pulls from column (c-r) mod 4.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[8*(15-bidx(r, c)) +: 8] = byte_at(st, bidx(r, (c - r + 4) % 4));
            end
        end
        for (int i = 0; i < 16; i++) begin
            t[8*(15-i) +: 8] = inv_sbox(byte_at(sr, i)) ^ byte_at(rk, i);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mc[8*(15-bidx(r, c)) +: 8] =
                    gf_mul(8'h0e, byte_at(t, bidx(r, c))) ^
                    gf_mul(8'h0b, byte_at(t, bidx((r + 1) % 4, c))) ^
                    gf_mul(8'h0d, byte_at(t, bidx((r + 2) % 4, c))) ^
                    gf_mul(8'h09, byte_at(t, bidx((r + 3) % 4, c)));
            end
        end
    end

    assign nxt = last ? t : mc;
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched by index each cycle.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_inv_cipher_iter_if.slave  bus
);
    state_t       state, state_nxt;
    logic [127:0] st, st_nxt;
    logic [3:0]   rnd, rnd_nxt;
    logic [127:0] round_nxt;

    aes_inv_round u_round (
        .st   (st),
        .rk   (bus.rk),
        .last (rnd == 4'd0),
        .nxt  (round_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rnd   <= '0;
        end else begin
            state <= state_nxt;
            st    <= st_nxt;
            rnd   <= rnd_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        st_nxt        = st;
        rnd_nxt       = rnd;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.rk_idx    = 4'(NR);
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    st_nxt    = bus.in_data ^ bus.rk;
                    rnd_nxt   = 4'(NR - 1);
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                bus.rk_idx = rnd;
                st_nxt     = round_nxt;
                if (rnd == 4'd0) begin
                    state_nxt = DONE;
                end else begin
                    rnd_nxt = rnd - 4'd1;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = st;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using the FIPS-197 C.1 vector and a plaintext scoreboard.
module tb_aes_inv_cipher_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_inv_cipher_iter_if ifc ();

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [127:0] r_st, r_rk, r_nxt;
    logic         r_last;

    aes_inv_round u_rnd (
        .st   (r_st),
        .rk   (r_rk),
        .last (r_last),
        .nxt  (r_nxt)
    );

    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEYS [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    // External key-schedule store, read combinationally by index.
    always_comb begin
        if (ifc.rk_idx <= 4'd10) ifc.rk = KEYS[int'(ifc.rk_idx)];
        else                     ifc.rk = '0;
    end

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk(tag, 128'(exp_q.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_out_valid", {127'd0, ifc.out_valid}, 128'd0);
            else                   chk("plaintext", ifc.out_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    logic [127:0] e;
    int dest;
    int acc [3];
    int nacc;
    int cyc;

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;
        r_st = '0; r_rk = '0; r_last = 1'b0;
        tick();
        tick();
        chk("reset_in_ready",  128'(ifc.in_ready),  128'd1);
        chk("reset_out_valid", 128'(ifc.out_valid), 128'd0);
        chk("reset_out_data",  ifc.out_data,        128'd0);
        chk("reset_rk_idx",    128'(ifc.rk_idx),    128'd10);
        rst = 1'b0;

        // C.1 block with latency and rk_idx trace
        ifc.in_data   = CT;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        chk("accept_rk_idx",   128'(ifc.rk_idx),   128'd10);
        chk("accept_in_ready", 128'(ifc.in_ready), 128'd1);
        exp_q.push_back(PT);
        tick();
        ifc.in_valid = 1'b0;
        ifc.in_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 10; k++) begin
            chk("round_rk_idx",    128'(ifc.rk_idx),    128'(10 - k));
            chk("round_out_valid", 128'(ifc.out_valid), 128'd0);
            chk("round_in_ready",  128'(ifc.in_ready),  128'd0);
            tick();
        end
        chk("c1_out_valid", 128'(ifc.out_valid), 128'd1);
        chk("c1_out_data",  ifc.out_data,        PT);
        chk("done_rk_idx",  128'(ifc.rk_idx),    128'd10);
        tick();
        chk("c1_ret_in_ready",  128'(ifc.in_ready),  128'd1);
        chk("c1_ret_out_valid", 128'(ifc.out_valid), 128'd0);

        // Backpressure hold in DONE with stray in_valid pulses
        ifc.out_ready = 1'b0;
        ifc.in_data   = CT;
        ifc.in_valid  = 1'b1;
        exp_q.push_back(PT);
        tick();
        ifc.in_valid = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 20; i++) begin
            chk("hold_out_valid", 128'(ifc.out_valid), 128'd1);
            chk("hold_out_data",  ifc.out_data,        PT);
            chk("hold_in_ready",  128'(ifc.in_ready),  128'd0);
            ifc.in_valid = (i % 2 == 1);
            ifc.in_data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        ifc.in_valid  = 1'b0;
        chk("hold_end_out_valid", 128'(ifc.out_valid), 128'd1);
        ifc.out_ready = 1'b1;
        tick();
        chk("hold_ret_in_ready",  128'(ifc.in_ready),  128'd1);
        chk("hold_ret_out_valid", 128'(ifc.out_valid), 128'd0);
        tick();
        chk("hold_no_extra_block", 128'(ifc.in_ready), 128'd1);

        // Back-to-back with in_valid and out_ready held high
        ifc.in_data  = CT;
        ifc.in_valid = 1'b1;
        nacc = 0;
        cyc  = 0;
        while (nacc < 3 && cyc < 100) begin
            if (ifc.in_ready) begin
                exp_q.push_back(PT);
                acc[nacc] = cyc;
                nacc++;
            end
            tick();
            cyc++;
        end
        ifc.in_valid = 1'b0;
        chk("b2b_accepts", 128'(nacc), 128'd3);
        chk("b2b_spacing_1", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b_spacing_2", 128'(acc[2] - acc[1]), 128'd12);
        drain("b2b_drain");

        // Reset on the 5th ROUND cycle discards the block
        ifc.in_data  = CT;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_rk_idx_before_rst", 128'(ifc.rk_idx), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready",  128'(ifc.in_ready),  128'd1);
        chk("mid_rst_out_valid", 128'(ifc.out_valid), 128'd0);
        chk("mid_rst_rk_idx",    128'(ifc.rk_idx),    128'd10);
        chk("mid_rst_out_data",  ifc.out_data,        128'd0);
        ifc.in_data  = CT;
        ifc.in_valid = 1'b1;
        exp_q.push_back(PT);
        tick();
        ifc.in_valid = 1'b0;
        drain("post_rst_drain");

        // Isolated round: InvMixColumns on column 0 (t = 0x52^rk after InvSubBytes of zeros)
        r_st   = '0;
        r_rk   = 128'hdc1ff3ee_52525252_52525252_52525252;
        r_last = 1'b0;
        #1;
        chk("inv_mixcol", r_nxt, 128'hdb135345_00000000_00000000_00000000);

        // InvShiftRows mapping: marker 0x63 decodes to 0x00, background 0x00 decodes to 0x52
        r_rk   = '0;
        r_last = 1'b1;
        for (int p = 0; p < 16; p++) begin
            r_st = '0;
            r_st[8*(15-p) +: 8] = 8'h63;
            dest = (p % 4) + 4 * (((p / 4) + (p % 4)) % 4);
            e = {16{8'h52}};
            e[8*(15-dest) +: 8] = 8'h00;
            #1;
            chk("inv_shiftrows_map", r_nxt, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
